// File: rtl/instr_encoder_loader.sv
// ============================================================================
// Module   : instr_encoder_loader
// Brief    : Encodes symbolic KGP-RISC instruction requests into 32-bit words
//            and writes them sequentially into instruction memory.
//            Optional readback verification: INSTR_ENC_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_opcode,
    input  logic [3:0]        in_fcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic              imem_re,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              illegal,
    output logic              verify_err,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
`ifdef INSTR_ENC_READBACK_EN
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;
`endif

    localparam logic [ADDR_W-1:0] c_base  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_last  = (ADDR_W+1)'(DEPTH - 1);

    logic [1:0]        r_state, w_state_n;
    logic [ADDR_W-1:0] r_ptr, w_ptr_n;
    logic [ADDR_W:0]   r_count, w_count_n;
    logic [31:0]       r_wdata, w_wdata_n;
    logic              r_full, w_full_n;
    logic              r_illegal, w_illegal_n;
    logic              r_done, w_done_n;
    logic              r_pend, w_pend_n;
    logic              r_ready, w_ready_n;
    logic              w_accept;
    logic              w_commit;
`ifdef INSTR_ENC_READBACK_EN
    logic              r_verr, w_verr_n;
`endif

    function automatic logic [31:0] f_encode(
        input logic [1:0]  op,
        input logic [3:0]  fc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm,
        input logic [25:0] tgt
    );
        logic [31:0] w;
        if (op == 2'd3) begin
            w = (fc == 4'd0) ? {op, fc, rs, 21'd0} : {op, fc, tgt};
        end else begin
            w = {op, fc, rs, rt, imm};
        end
        return w;
    endfunction

    function automatic logic f_legal(input logic [1:0] op, input logic [3:0] fc);
        logic ok;
        case (op)
            2'd0:    ok = (fc <= 4'd1);
            2'd1:    ok = (fc <= 4'd8);
            2'd2:    ok = (fc <= 4'd4);
            default: ok = (fc <= 4'd11);
        endcase
        return ok;
    endfunction

    // start and finish both pre-empt a simultaneous request.
    assign w_accept = (r_state == S_IDLE) && r_ready && in_valid && !start && !finish;

    always_comb begin
        w_state_n   = r_state;
        w_ptr_n     = r_ptr;
        w_count_n   = r_count;
        w_wdata_n   = r_wdata;
        w_full_n    = r_full;
        w_illegal_n = r_illegal;
        w_done_n    = r_done;
        w_pend_n    = r_pend;
        w_commit    = 1'b0;
`ifdef INSTR_ENC_READBACK_EN
        w_verr_n    = r_verr;
`endif

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_ptr_n     = c_base;
                    w_count_n   = '0;
                    w_full_n    = 1'b0;
                    w_illegal_n = 1'b0;
                    w_done_n    = 1'b0;
                    w_pend_n    = 1'b0;
`ifdef INSTR_ENC_READBACK_EN
                    w_verr_n    = 1'b0;
`endif
                end else if (finish) begin
                    w_done_n = 1'b1;
                end else if (w_accept) begin
                    if (f_legal(in_opcode, in_fcode)) begin
                        w_wdata_n = f_encode(in_opcode, in_fcode, in_rs, in_rt, in_imm, in_target);
                        w_state_n = S_WRITE;
                    end else begin
                        w_illegal_n = 1'b1;
                    end
                end
            end
`ifdef INSTR_ENC_READBACK_EN
            S_WRITE: w_state_n = S_READ;
            S_READ:  w_state_n = S_CHECK;
            S_CHECK: begin
                if (imem_rdata != r_wdata) begin
                    w_verr_n = 1'b1;
                end
                w_commit  = 1'b1;
                w_state_n = S_IDLE;
            end
`else
            S_WRITE: begin
                w_commit  = 1'b1;
                w_state_n = S_IDLE;
            end
`endif
            default: w_state_n = S_IDLE;
        endcase

        // Pointer stops on the last slot so it never wraps past the program.
        if (w_commit) begin
            w_count_n = r_count + 1'b1;
            w_full_n  = ((r_count + 1'b1) == c_depth);
            if (r_count != c_last) begin
                w_ptr_n = r_ptr + 1'b1;
            end
        end

        // finish outside IDLE is remembered and applied on the return to IDLE.
        if (r_state != S_IDLE) begin
            if (w_state_n == S_IDLE) begin
                if (finish || r_pend) begin
                    w_done_n = 1'b1;
                end
                w_pend_n = 1'b0;
            end else if (finish) begin
                w_pend_n = 1'b1;
            end
        end

        w_ready_n = (w_state_n == S_IDLE) && !w_full_n && !w_done_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= c_base;
            r_count   <= '0;
            r_wdata   <= '0;
            r_full    <= 1'b0;
            r_illegal <= 1'b0;
            r_done    <= 1'b0;
            r_pend    <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_ptr     <= w_ptr_n;
            r_count   <= w_count_n;
            r_wdata   <= w_wdata_n;
            r_full    <= w_full_n;
            r_illegal <= w_illegal_n;
            r_done    <= w_done_n;
            r_pend    <= w_pend_n;
            r_ready   <= w_ready_n;
        end
    end

`ifdef INSTR_ENC_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_verr <= 1'b0;
        end else begin
            r_verr <= w_verr_n;
        end
    end

    assign imem_re    = (r_state == S_READ);
    assign verify_err = r_verr;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^imem_rdata;
    assign imem_re        = 1'b0;
    assign verify_err     = 1'b0;
`endif

    assign in_ready   = r_ready;
    assign imem_we    = (r_state == S_WRITE);
    assign imem_addr  = r_ptr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign full       = r_full;
    assign illegal    = r_illegal;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Producer-side counterpart of the processor's opcode/fcode decode: accepts symbolic instruction requests (opcode, fcode, operand fields) over a valid/ready handshake.
- Encodes each request into a 32-bit KGP-RISC instruction word and writes it sequentially into instruction memory.
- Used by the boot/test harness to load programs before the core is released from reset.
- Rejects opcode/fcode combinations the core cannot decode.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- BASE_ADDR, 0, first word address written after start.
- DEPTH, 1024, maximum words loadable per program (must be ≤ 2^ADDR_W).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  pulse; sets pointer to BASE_ADDR and clears count/done/full/illegal/verify_err.
- finish  input  1  pulse; marks program complete.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_opcode  input  2  major opcode.
- in_fcode  input  4  function code.
- in_rs  input  5  source/base register.
- in_rt  input  5  second/destination register.
- in_imm  input  16  immediate/offset.
- in_target  input  26  branch target field.
- imem_we  output  1  instruction memory write strobe.
- imem_re  output  1  instruction memory read strobe (readback).
- imem_addr  output  ADDR_W  memory word address.
- imem_wdata  output  32  encoded word.
- imem_rdata  input  32  synchronous read data, valid the cycle after imem_re.
- count  output  ADDR_W+1  words written since start.
- full  output  1  count == DEPTH.
- illegal  output  1  sticky; an illegal request was rejected.
- verify_err  output  1  sticky; readback mismatch.
- done  output  1  sticky after finish.

Behaviour:
- Reset: in_ready=0, imem_we=0, imem_re=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, illegal=0, verify_err=0, done=0, state=IDLE.
- Encoding:
  - bits [31:30] = opcode, bits [29:26] = fcode.
  - Opcode 0/1/2: [25:21]=rs, [20:16]=rt, [15:0]=imm.
  - Opcode 3 with fcode 0: [25:21]=rs, [20:0]=0.
  - Opcode 3 with other fcode: [25:0]=target.
- Legal fcodes:
  - opcode 0: 0-1.
  - opcode 1: 0-8.
  - opcode 2: 0-4.
  - opcode 3: 0-11.
- FSM states: IDLE, WRITE, READ, CHECK.
- IDLE:
  - in_ready = !full && !done.
  - On acceptance of a legal request: latch encoded word into imem_wdata, go to WRITE.
  - On acceptance of an illegal request: set illegal, no write, pointer unchanged, stay in IDLE.
- WRITE: one cycle with imem_we=1 and imem_addr=pointer. Then the pointer increments, count increments, and the FSM returns to IDLE (or goes to READ when the optional feature is enabled).
- Throughput: one word per 2 cycles, or per 4 cycles with readback.
- Full:
  - full asserts in the cycle after the DEPTH-th write.
  - in_ready stays 0 while full.
  - Pointer saturates; it never wraps.
- start:
  - Honoured only in IDLE; ignored in other states.
  - Takes priority over a simultaneous in_valid, which is not accepted that cycle.
- finish:
  - Sets done in IDLE.
  - In any other state, done is set upon the return to IDLE.
  - A request arriving with finish in the same cycle is not accepted.
- Reset mid-operation: an in-flight write is abandoned. imem_we drops in the cycle reset is sampled, and all state returns to reset values.
- in_ready is registered-state-based only and combinationally independent of in_valid.

Optional Feature:
- Macro: INSTR_ENC_READBACK_EN.
- Defined:
  - After WRITE, the READ state drives imem_re=1 at the same address (pre-increment address held).
  - In CHECK, imem_rdata is compared with imem_wdata; a mismatch sets verify_err.
  - The FSM then returns to IDLE.
- Undefined:
  - READ and CHECK are absent.
  - imem_re is tied 0, imem_rdata is ignored, and verify_err is tied 0.

Test Plan:
- Reset, start, then opcode=1 fcode=2 rs=3 rt=4 -> one imem_we pulse, addr=0, wdata=0x48640000, count=1.
- opcode=0 fcode=0 rs=1 rt=2 imm=0x0010 then opcode=3 fcode=3 target=0x40 -> writes 0x00220010 at addr 0 and 0xCC000040 at addr 1.
- opcode=2 fcode=7 -> no imem_we, illegal=1, count unchanged; the next legal request writes at the same address.
- DEPTH=4, five back-to-back requests -> four writes at addr 0-3, full=1, in_ready=0, fifth request held off. start then clears full.
- rst asserted during WRITE -> imem_we=0 the next cycle, all outputs at reset values, no pointer increment.
- INSTR_ENC_READBACK_EN defined, memory model corrupts bit 0 on readback -> verify_err=1 after the CHECK cycle. With the macro undefined, verify_err stays 0 and imem_re is never asserted.
